// File: rtl/bpb_gshare_predictor.sv
// bpb_gshare_predictor
//
// Branch prediction buffer for the fetch/decode pipeline. The fetch stage
// gets a same-cycle taken/target prediction from a direct-mapped BTB
// (valid, partial tag, target) and a PHT of saturating counters. The PHT is
// indexed by the PC index alone (GSHARE=0) or by PC index XOR the
// speculative global history (GSHARE=1). The decode stage trains the tables
// with the resolved outcome. A one-entry snapshot of the fetch-time lookup
// lets that resolution reach the PHT entry the prediction actually used, and
// lets the speculative history be repaired on a mispredict.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high
//   stall_d       decode stalled: freezes snapshot, history shift, training
//   flush_d       fetch-stage instruction squashed this cycle
//   pc_f          fetch PC
//   is_branch_f   predecoded conditional branch at pc_f
//   prd_taken_f   predicted taken (combinational)
//   prd_target_f  predicted next PC (combinational)
//   upd_valid     branch in decode resolved this cycle
//   upd_pc        PC of the resolved branch
//   upd_taken     actual outcome
//   upd_target    actual taken target
//   mispredict_d  resolved branch was mispredicted (combinational)

module bpb_gshare_predictor #(
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int CNT_WIDTH   = 2,
  parameter int GSHARE      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic [31:0] pc_f,
  input  logic        is_branch_f,
  output logic        prd_taken_f,
  output logic [31:0] prd_target_f,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        mispredict_d
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

  // Saturating counter step: up on taken, down on not-taken, clamped at both ends.
  function automatic logic [CNT_WIDTH-1:0] cnt_sat_step(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 up
  );
    logic [CNT_WIDTH-1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != CNT_MAX) res = cnt + CNT_WIDTH'(1);
    end else begin
      if (cnt != '0) res = cnt - CNT_WIDTH'(1);
    end
    return res;
  endfunction

  // Prediction tables, held in flops.
  logic                   btb_valid  [ENTRIES];
  logic [TAG_WIDTH-1:0]   btb_tag    [ENTRIES];
  logic [31:0]            btb_target [ENTRIES];
  logic [CNT_WIDTH-1:0]   pht        [ENTRIES];

  // Speculative history and the in-flight snapshot of the last fetch lookup.
  logic [INDEX_WIDTH-1:0] ghr_spec;
  logic [INDEX_WIDTH-1:0] ghr_next;
  logic [INDEX_WIDTH-1:0] inf_ghr;
  logic                   inf_taken;
  logic [31:0]            inf_target;

  // ---------------------------------------------------------------------------
  // Fetch-stage lookup (combinational, reads pre-write table contents)
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] idx_f;
  logic [TAG_WIDTH-1:0]   tag_f;
  logic [INDEX_WIDTH-1:0] pht_idx_f;
  logic [CNT_WIDTH-1:0]   cnt_f;
  logic                   btb_hit_f;
  logic [31:0]            seq_pc_f;

  assign idx_f     = pc_f[INDEX_WIDTH+1:2];
  assign tag_f     = pc_f[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  assign pht_idx_f = (GSHARE != 0) ? (idx_f ^ ghr_spec) : idx_f;
  assign cnt_f     = pht[pht_idx_f];
  assign btb_hit_f = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
  assign seq_pc_f  = pc_f + 32'd4;

  assign prd_taken_f  = is_branch_f & btb_hit_f & cnt_f[CNT_WIDTH-1] & ~reset;
  assign prd_target_f = prd_taken_f ? btb_target[idx_f] : seq_pc_f;

  // ---------------------------------------------------------------------------
  // Decode-stage resolution
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [TAG_WIDTH-1:0]   upd_tag;
  logic [INDEX_WIDTH-1:0] upd_pht_idx;
  logic                   train_en;
  logic                   unused_upd_pc;

  assign upd_idx     = upd_pc[INDEX_WIDTH+1:2];
  assign upd_tag     = upd_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  // The counter trained is the one the fetch lookup read, so gshare mode
  // uses the history captured at fetch time, not the current one.
  assign upd_pht_idx = (GSHARE != 0) ? (upd_idx ^ inf_ghr) : upd_idx;
  assign train_en    = upd_valid & ~stall_d & ~reset;
  // Bits of upd_pc outside the index/tag fields carry no information here.
  assign unused_upd_pc = ^upd_pc;

  assign mispredict_d = train_en &
                        ((upd_taken != inf_taken) |
                         (upd_taken & (upd_target != inf_target)));

  // History repair takes priority over the fetch-side shift: the repaired
  // value is rebuilt from the snapshot plus the real outcome, so anything
  // fetched speculatively in the same cycle is dropped.
  always_comb begin
    ghr_next = ghr_spec;
    if (mispredict_d) begin
      ghr_next = (inf_ghr << 1) | INDEX_WIDTH'(upd_taken);
    end else if (is_branch_f & ~stall_d & ~flush_d) begin
      ghr_next = (ghr_spec << 1) | INDEX_WIDTH'(prd_taken_f);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered state: history, snapshot, tables
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_spec <= '0;
    end else begin
      ghr_spec <= ghr_next;
    end
  end

  // A squashed fetch leaves a "predicted not-taken, target 0" snapshot so its
  // stale prediction never masks a later resolution.
  always_ff @(posedge clk) begin
    if (reset) begin
      inf_ghr    <= '0;
      inf_taken  <= 1'b0;
      inf_target <= '0;
    end else if (!stall_d) begin
      inf_ghr    <= ghr_spec;
      inf_taken  <= prd_taken_f & ~flush_d;
      inf_target <= flush_d ? 32'd0 : prd_target_f;
    end
  end

  // Tags and targets are only meaningful behind a set valid bit, so only the
  // valid bits and counters are cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        pht[i]       <= CNT_WEAK_NT;
      end
    end else if (train_en) begin
      pht[upd_pht_idx] <= cnt_sat_step(pht[upd_pht_idx], upd_taken);
      if (upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target;
      end
    end
  end

endmodule

// File: tb/tb_bpb_gshare_predictor.sv
// tb_bpb_gshare_predictor
//
// Drives a bimodal instance (GSHARE=0) and a gshare instance (GSHARE=1) with
// the same stimulus and compares both against a table-level reference model
// each cycle, with directed sequences for counter training, saturation,
// aliasing, history repair, stall, flush and reset.

module tb_bpb_gshare_predictor;

  localparam int IW    = 4;
  localparam int TW    = 8;
  localparam int CW    = 2;
  localparam int N     = 1 << IW;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int CWEAK = (1 << (CW - 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall_d, flush_d, is_branch_f, upd_valid, upd_taken;
  logic [31:0] pc_f, upd_pc, upd_target;
  logic [1:0]  prd_taken, mis;
  logic [31:0] prd_target0, prd_target1;

  int n_tests = 0;
  int n_fail  = 0;

  bpb_gshare_predictor #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW), .CNT_WIDTH(CW), .GSHARE(0)) dut0 (
    .clk(clk), .reset(reset), .stall_d(stall_d), .flush_d(flush_d),
    .pc_f(pc_f), .is_branch_f(is_branch_f),
    .prd_taken_f(prd_taken[0]), .prd_target_f(prd_target0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispredict_d(mis[0])
  );

  bpb_gshare_predictor #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW), .CNT_WIDTH(CW), .GSHARE(1)) dut1 (
    .clk(clk), .reset(reset), .stall_d(stall_d), .flush_d(flush_d),
    .pc_f(pc_f), .is_branch_f(is_branch_f),
    .prd_taken_f(prd_taken[1]), .prd_target_f(prd_target1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispredict_d(mis[1])
  );

  // Reference model state, one copy per instance (index 1 = gshare).
  bit          m_val   [2][N];
  int          m_tag   [2][N];
  logic [31:0] m_tgt   [2][N];
  int          m_cnt   [2][N];
  int          m_ghr   [2];
  int          m_ighr  [2];
  bit          m_itaken[2];
  logic [31:0] m_itgt  [2];

  bit          e_taken [2];
  logic [31:0] e_target[2];
  bit          e_mis   [2];

  bit          obs_taken [2];
  logic [31:0] obs_target[2];
  bit          obs_mis   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int m_tagf(input logic [31:0] pc);
    return int'((pc >> (IW + 2)) % (1 << TW));
  endfunction

  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      int  i, p;
      bit  hit;
      i   = m_idx(pc_f);
      p   = (d == 1) ? (i ^ m_ghr[d]) : i;
      hit = m_val[d][i] && (m_tag[d][i] == m_tagf(pc_f));
      e_taken[d]  = !reset && is_branch_f && hit && (m_cnt[d][p] >= (1 << (CW - 1)));
      e_target[d] = e_taken[d] ? m_tgt[d][i] : pc_f + 32'd4;
      e_mis[d]    = !reset && upd_valid && !stall_d &&
                    ((upd_taken != m_itaken[d]) ||
                     (upd_taken && (upd_target != m_itgt[d])));
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int i = 0; i < N; i++) begin
          m_val[d][i] = 1'b0;
          m_cnt[d][i] = CWEAK;
        end
        m_ghr[d]    = 0;
        m_ighr[d]   = 0;
        m_itaken[d] = 1'b0;
        m_itgt[d]   = 32'd0;
      end else begin
        int old_ghr;
        old_ghr = m_ghr[d];
        if (upd_valid && !stall_d) begin
          int ui, pi;
          ui = m_idx(upd_pc);
          pi = (d == 1) ? (ui ^ m_ighr[d]) : ui;
          if (upd_taken) begin
            if (m_cnt[d][pi] < CMAX) m_cnt[d][pi] = m_cnt[d][pi] + 1;
            m_val[d][ui] = 1'b1;
            m_tag[d][ui] = m_tagf(upd_pc);
            m_tgt[d][ui] = upd_target;
          end else begin
            if (m_cnt[d][pi] > 0) m_cnt[d][pi] = m_cnt[d][pi] - 1;
          end
        end
        if (e_mis[d])
          m_ghr[d] = (m_ighr[d] * 2 + int'(upd_taken)) % N;
        else if (is_branch_f && !stall_d && !flush_d)
          m_ghr[d] = (old_ghr * 2 + int'(e_taken[d])) % N;
        if (!stall_d) begin
          m_ighr[d]   = old_ghr;
          m_itaken[d] = flush_d ? 1'b0 : e_taken[d];
          m_itgt[d]   = flush_d ? 32'd0 : e_target[d];
        end
      end
    end
  endtask

  // One clock: outputs checked at the falling edge, state after the rising edge.
  task automatic run_cycle();
    @(negedge clk);
    model_eval();
    obs_taken[0]  = prd_taken[0];
    obs_taken[1]  = prd_taken[1];
    obs_target[0] = prd_target0;
    obs_target[1] = prd_target1;
    obs_mis[0]    = mis[0];
    obs_mis[1]    = mis[1];
    check("taken0",  32'(obs_taken[0]), 32'(e_taken[0]));
    check("taken1",  32'(obs_taken[1]), 32'(e_taken[1]));
    check("target0", obs_target[0], e_target[0]);
    check("target1", obs_target[1], e_target[1]);
    check("mis0",    32'(obs_mis[0]), 32'(e_mis[0]));
    check("mis1",    32'(obs_mis[1]), 32'(e_mis[1]));
    @(posedge clk);
    model_update();
    #1;
    check("ghr0", 32'(dut0.ghr_spec), 32'(m_ghr[0]));
    check("ghr1", 32'(dut1.ghr_spec), 32'(m_ghr[1]));
  endtask

  task automatic drive(input bit rst, input bit stl, input bit fl,
                       input logic [31:0] pc, input bit br,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt);
    reset       = rst;
    stall_d     = stl;
    flush_d     = fl;
    pc_f        = pc;
    is_branch_f = br;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utgt;
    run_cycle();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'h0040_0000 | (32'($urandom_range(0, 31)) << 2);
    if ($urandom_range(0, 3) == 0) pc = pc | 32'h0000_1000;
    return pc;
  endfunction

  localparam logic [31:0] BR   = 32'h0040_0020;
  localparam logic [31:0] BTGT = 32'h0040_0100;
  localparam logic [31:0] IDLE = 32'h0040_0000;

  initial begin
    // Reset and post-reset lookup
    drive(1, 0, 0, IDLE, 0, 0, 0, 0, 0);
    drive(1, 0, 0, IDLE, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0040_0010, 1, 0, 0, 0, 0);
    check("rst_taken0",  32'(obs_taken[0]), 32'd0);
    check("rst_taken1",  32'(obs_taken[1]), 32'd0);
    check("rst_target0", obs_target[0], 32'h0040_0014);
    check("rst_cnt",     32'(dut0.pht[8]), 32'(CWEAK));

    // Bimodal training sequence on 0x00400020
    drive(0, 0, 0, BR, 1, 1, BR, 1, BTGT);
    check("res1_mis",  32'(obs_mis[0]), 32'd1);
    check("res1_pre",  32'(obs_taken[0]), 32'd0);
    check("res1_cnt",  32'(dut0.pht[8]), 32'd2);
    drive(0, 0, 0, BR, 1, 0, 0, 0, 0);
    check("pred_cnt2", 32'(obs_taken[0]), 32'd1);
    drive(0, 0, 0, IDLE, 0, 1, BR, 1, BTGT);
    check("res2_mis",  32'(obs_mis[0]), 32'd0);
    check("res2_cnt",  32'(dut0.pht[8]), 32'd3);
    drive(0, 0, 0, BR, 1, 0, 0, 0, 0);
    check("pred_taken",  32'(obs_taken[0]), 32'd1);
    check("pred_target", obs_target[0], BTGT);

    // Saturation, then two not-taken resolutions
    for (int k = 0; k < 4; k++) drive(0, 0, 0, IDLE, 0, 1, BR, 1, BTGT);
    check("sat_cnt", 32'(dut0.pht[8]), 32'd3);
    drive(0, 0, 0, BR, 1, 0, 0, 0, 0);
    drive(0, 0, 0, BR, 1, 1, BR, 0, 0);
    check("nt1_mis", 32'(obs_mis[0]), 32'd1);
    check("nt1_cnt", 32'(dut0.pht[8]), 32'd2);
    drive(0, 0, 0, BR, 1, 1, BR, 0, 0);
    check("nt1_still_taken", 32'(obs_taken[0]), 32'd1);
    check("nt2_cnt", 32'(dut0.pht[8]), 32'd1);
    drive(0, 0, 0, BR, 1, 0, 0, 0, 0);
    check("nt2_pred", 32'(obs_taken[0]), 32'd0);

    // Alias: same index, different tag
    drive(0, 0, 0, IDLE, 0, 1, BR, 1, BTGT);
    drive(0, 0, 0, 32'h0040_1020, 1, 0, 0, 0, 0);
    check("alias_taken",  32'(obs_taken[0]), 32'd0);
    check("alias_target", obs_target[0], 32'h0040_1024);

    // Gshare history repair: build inf_ghr=0010, then mispredict with fetch shift
    drive(1, 0, 0, IDLE, 0, 0, 0, 0, 0);
    drive(0, 0, 0, IDLE, 0, 0, 0, 0, 0);
    drive(0, 0, 0, IDLE, 0, 1, 32'h0040_0040, 1, 32'h0040_0200);
    drive(0, 0, 0, 32'h0040_0084, 1, 0, 0, 0, 0);
    check("ghr_build", 32'(dut1.ghr_spec), 32'd2);
    drive(0, 0, 0, IDLE, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0040_008C, 1, 1, 32'h0040_0084, 1, 32'h0040_0300);
    check("repair_mis", 32'(obs_mis[1]), 32'd1);
    check("repair_ghr", 32'(dut1.ghr_spec), 32'd5);

    // Stall holds everything
    drive(1, 0, 0, IDLE, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, BR, 1, 1, BR, 1, BTGT);
      check("stall_mis0", 32'(obs_mis[0]), 32'd0);
      check("stall_mis1", 32'(obs_mis[1]), 32'd0);
    end
    check("stall_cnt",   32'(dut0.pht[8]), 32'(CWEAK));
    check("stall_valid", 32'(dut0.btb_valid[8]), 32'd0);

    // Flush leaves history alone
    drive(0, 0, 0, IDLE, 0, 1, BR, 1, BTGT);
    check("pre_flush_ghr", 32'(dut1.ghr_spec), 32'd1);
    drive(0, 0, 1, 32'h0040_0084, 1, 0, 0, 0, 0);
    check("flush_ghr", 32'(dut1.ghr_spec), 32'd1);

    // Reset during training
    drive(1, 0, 0, BR, 1, 1, BR, 1, BTGT);
    check("rst_upd_mis",   32'(obs_mis[0]), 32'd0);
    check("rst_upd_taken", 32'(obs_taken[0]), 32'd0);
    check("rst_upd_cnt",   32'(dut0.pht[8]), 32'(CWEAK));
    check("rst_upd_valid", 32'(dut0.btb_valid[8]), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] pc, upc, utgt;
      bit          ut;
      pc   = rand_pc();
      upc  = ($urandom_range(0, 1) == 0) ? pc_f : rand_pc();
      ut   = ($urandom_range(0, 2) != 0);
      utgt = 32'h0040_0000 + 32'($urandom_range(0, 3)) * 32'h100;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), pc, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0), upc, ut, utgt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
